// File: rtl/mem_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter_pkg
// Description : Shared types for the cache-to-memory request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_req_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;
  localparam int MEM_WB_DEPTH = 4;
  localparam int BLOCK_BYTES  = 8;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } MEM_COMMAND;

  typedef struct packed {
    logic valid;
    ADDR  addr;
  } I_ADDR_PACKET;

  typedef struct packed {
    logic     valid;
    ADDR      addr;
    MEM_BLOCK data;
  } WB_ENTRY;

  typedef enum logic {
    DC = 1'b0,
    IC = 1'b1
  } TAG_OWNER;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_STORE = 2'd1,
    GNT_DC    = 2'd2,
    GNT_IC    = 2'd3
  } GRANT_SEL;

  function automatic ADDR block_addr(input ADDR a);
    return a & ~ADDR'(BLOCK_BYTES - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Writeback FIFO with parallel block-address match for hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = MEM_WB_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  ADDR                    push_addr,
  input  MEM_BLOCK               push_data,
  input  logic                   pop,
  output WB_ENTRY                head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  input  ADDR                    dc_match_addr,
  input  ADDR                    ic_match_addr,
  output logic                   dc_hit,
  output logic                   ic_hit
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
  localparam logic [PTR_W:0]   c_cnt_one  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   c_cnt_full = (PTR_W + 1)'(DEPTH);

  WB_ENTRY          r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;

  // When full, a push only lands if the head slot is freed in the same cycle.
  assign w_push_ok = push && (!full || pop);
  assign full      = (r_count == c_cnt_full);
  assign count     = r_count;
  assign head      = r_mem[r_head];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (pop) begin
        r_mem[r_head].valid <= 1'b0;
        r_head              <= r_head + c_ptr_one;
      end
      if (w_push_ok) begin
        r_mem[r_tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        r_tail        <= r_tail + c_ptr_one;
      end
      case ({w_push_ok, pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    dc_hit = 1'b0;
    ic_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dc_hit = dc_hit | (r_mem[i].valid && (r_mem[i].addr == dc_match_addr));
      ic_hit = ic_hit | (r_mem[i].valid && (r_mem[i].addr == ic_match_addr));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Arbitrates cache reads and writebacks onto one memory port and
//               steers tagged returns to the owning cache.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int WB_DEPTH = MEM_WB_DEPTH,
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic         clock,
  input  logic         reset,
  input  I_ADDR_PACKET dc_req_addr,
  output logic         dc_req_accepted,
  output MEM_TAG       dc_req_tag,
  input  I_ADDR_PACKET dc_wb_addr,
  input  MEM_BLOCK     dc_wb_data,
  input  logic         dc_wb_valid,
  input  I_ADDR_PACKET ic_req_addr,
  output logic         ic_req_accepted,
  output MEM_TAG       ic_req_tag,
  output MEM_COMMAND   proc2mem_command,
  output ADDR          proc2mem_addr,
  output MEM_BLOCK     proc2mem_data,
  input  MEM_TAG       mem2proc_transaction_tag,
  input  MEM_BLOCK     mem2proc_data,
  input  MEM_TAG       mem2proc_data_tag,
  output MEM_TAG       dc_data_tag,
  output MEM_TAG       ic_data_tag,
  output MEM_BLOCK     mem_data,
  output logic         wb_overflow
);

  localparam int CNT_W = $clog2(WB_DEPTH) + 1;

  WB_ENTRY          w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full, w_dc_hit, w_ic_hit;
  logic             w_accept, w_pop, w_drop, w_alloc, w_ret_hit;
  GRANT_SEL         w_grant;
  TAG_OWNER         w_alloc_owner;
  ADDR              w_dc_blk, w_ic_blk, w_wb_blk;
  logic             w_unused_bits;

  logic             r_own_valid [NUM_TAGS+1];
  TAG_OWNER         r_own_owner [NUM_TAGS+1];
  logic             r_overflow;

  assign w_dc_blk      = block_addr(dc_req_addr.addr);
  assign w_ic_blk      = block_addr(ic_req_addr.addr);
  assign w_wb_blk      = block_addr(dc_wb_addr.addr);
  assign w_unused_bits = dc_wb_addr.valid ^ w_head.valid;

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
    .clock         (clock),
    .reset         (reset),
    .push          (dc_wb_valid),
    .push_addr     (w_wb_blk),
    .push_data     (dc_wb_data),
    .pop           (w_pop),
    .head          (w_head),
    .count         (w_count),
    .full          (w_full),
    .dc_match_addr (w_dc_blk),
    .ic_match_addr (w_ic_blk),
    .dc_hit        (w_dc_hit),
    .ic_hit        (w_ic_hit)
  );

  // Gated by reset so nothing is issued while the block is held in reset.
  always_comb begin
    w_grant = GNT_NONE;
    if (reset) begin
      if (w_full)                                w_grant = GNT_STORE;
      else if (dc_req_addr.valid && !w_dc_hit)   w_grant = GNT_DC;
      else if (ic_req_addr.valid && !w_ic_hit)   w_grant = GNT_IC;
      else if (w_count != '0)                    w_grant = GNT_STORE;
    end
  end

  assign w_accept      = (w_grant != GNT_NONE) && (mem2proc_transaction_tag != '0);
  assign w_pop         = w_accept && (w_grant == GNT_STORE);
  assign w_alloc       = w_accept && ((w_grant == GNT_DC) || (w_grant == GNT_IC))
                         && (int'(mem2proc_transaction_tag) <= NUM_TAGS);
  assign w_alloc_owner = (w_grant == GNT_IC) ? IC : DC;
  assign w_drop        = dc_wb_valid && w_full && !w_pop;

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    dc_req_accepted  = 1'b0;
    dc_req_tag       = '0;
    ic_req_accepted  = 1'b0;
    ic_req_tag       = '0;
    case (w_grant)
      GNT_STORE: begin
        proc2mem_command = MEM_STORE;
        proc2mem_addr    = w_head.addr;
        proc2mem_data    = w_head.data;
      end
      GNT_DC: begin
        proc2mem_command = MEM_LOAD;
        proc2mem_addr    = w_dc_blk;
        dc_req_accepted  = w_accept;
        dc_req_tag       = w_accept ? mem2proc_transaction_tag : '0;
      end
      GNT_IC: begin
        proc2mem_command = MEM_LOAD;
        proc2mem_addr    = w_ic_blk;
        ic_req_accepted  = w_accept;
        ic_req_tag       = w_accept ? mem2proc_transaction_tag : '0;
      end
      default: ;
    endcase
  end

  assign w_ret_hit   = reset && (mem2proc_data_tag != '0)
                       && (int'(mem2proc_data_tag) <= NUM_TAGS)
                       && r_own_valid[mem2proc_data_tag];
  assign dc_data_tag = (w_ret_hit && (r_own_owner[mem2proc_data_tag] == DC)) ? mem2proc_data_tag : '0;
  assign ic_data_tag = (w_ret_hit && (r_own_owner[mem2proc_data_tag] == IC)) ? mem2proc_data_tag : '0;
  assign mem_data    = reset ? mem2proc_data : '0;
  assign wb_overflow = r_overflow;

  // Clear precedes allocation so a tag returned and re-issued together stays owned.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= NUM_TAGS; i++) begin
        r_own_valid[i] <= 1'b0;
        r_own_owner[i] <= DC;
      end
      r_overflow <= 1'b0;
    end else begin
      if (w_ret_hit) r_own_valid[mem2proc_data_tag] <= 1'b0;
      if (w_alloc) begin
        r_own_valid[mem2proc_transaction_tag] <= 1'b1;
        r_own_owner[mem2proc_transaction_tag] <= w_alloc_owner;
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire
